md_unit_e: RTL and testbench
============================

Name: md_unit_e

Overview:
- E-stage multiply/divide unit. It takes the same forwarded operands (in1E/in2E) that the ALU takes, and it owns the architectural HI/LO registers.
- Its read output (mdOutE) is muxed with aluOutE into the E-stage result.
- Multi-cycle ops raise busyE. The hazard unit uses busyE to stall the D stage.

Parameters:
- MULT_CYCLES, 5, cycles busyE stays high after a MULT/MULTU issue (>=1).
- DIV_CYCLES, 10, cycles busyE stays high after a DIV/DIVU issue (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in1E  in  32  operand rs (forwarded).
- in2E  in  32  operand rt (forwarded).
- mdCtrE  in  4  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE.
- startE  in  1  high while a valid MD instruction occupies E; qualifies mdCtrE for ops 1-6.
- busyE  out  1  a multi-cycle op is in progress.
- mdOutE  out  32  HI when mdCtrE=MFHI, LO when mdCtrE=MFLO, else 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; ports are clk and rst_n.
- Reset values: HI=0, LO=0, busyE=0, counter=0, state IDLE, shadow result=0.
- State machine:
  - IDLE: on rising edge with startE=1 and mdCtrE in {1..4}, latch the operands, compute the 64-bit result into shadow regs, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - BUSY: busyE=1 (registered, so visible the cycle after issue). Counter decrements each edge. On the edge where the counter goes 1->0, commit shadow to HI/LO, clear busyE, return to IDLE.
  - Result: a result issued at edge t is readable via MFHI/MFLO at edge t+N+1 (N = cycle count).
- Arithmetic:
  - MULT: signed 32x32->64. MULTU: unsigned 32x32->64. HI = upper 32 bits, LO = lower 32 bits.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero (DIV or DIVU): still goes busy for DIV_CYCLES, then commits nothing; HI/LO keep their prior values.
- MTHI/MTLO: with startE=1 and busyE=0, write in1E to HI or LO at the edge. No busy cycle. The new value is visible next cycle.
- MFHI/MFLO: combinational read of the committed HI/LO. No startE qualification is needed.
- Protocol (the hazard unit guarantees it; the unit must tolerate violations):
  - startE with ops 1-6 while busyE=1 is ignored: no restart, no HI/LO write.
  - MF reads while busy return the old committed values.
- Issue-edge decision: the hazard unit stalls any MD instruction in D while (startE && mdCtrE in 1..4) || busyE. This covers the issue cycle, before busyE rises.
- Reset mid-operation: abort immediately. Shadow is discarded; HI/LO=0; busyE=0.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Decomposition:
- Shared package:
  - MD op encodings (MD_NONE..MD_MFLO). The controller decode uses the same encodings.
  - Default cycle counts.
- Sub-module md_arith:
  - Purely combinational, 64-bit result from op/in1/in2.
  - Includes the signed/unsigned and div-by-zero/overflow rules plus a valid flag (0 on div-by-zero).
  - Keeps the FSM, counter and HI/LO in md_unit_e.

Test Plan:
- Signed multiply timing: MULT in1=0xFFFFFFFD (-3), in2=5 -> busyE high for exactly 5 cycles starting the cycle after issue; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFF1.
- Unsigned multiply: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide, negative dividend: DIV -7 / 2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed divide, overflow: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload with MTHI 0x1234 and MTLO 0x5678, then DIVU x/0 -> busy 10 cycles; afterwards HI=0x1234, LO=0x5678.
- Ignored issue and reset abort:
  - MTLO 0xAAAA issued while busy -> ignored; LO only changes at commit.
  - New MULT issued while busy -> no restart; busy still ends on the original count.
  - rst_n pulled low mid-DIV -> busyE, HI and LO are 0 immediately, asynchronously to clk.

Source files
------------

// File: rtl/md_unit_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, FSM states and the HI/LO result pair.
package md_unit_e_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // MD op encodings, shared with the controller decode
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_pair_t;

  // True for the ops that occupy the unit for several cycles
  function automatic logic is_multi(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports: op (MD op code), in1/in2 (operands), res (HI/LO pair),
//        valid (0 when a divide has a zero divisor).
module md_arith
  import md_unit_e_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output md_pair_t        res,
  output logic            valid
);

  logic [2*XLEN-1:0] smul;
  logic [2*XLEN-1:0] umul;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN-1:0]   den;
  logic [XLEN-1:0]   uq;
  logic [XLEN-1:0]   ur;
  logic              sdiv;

  assign smul = $signed({{XLEN{in1[XLEN-1]}}, in1}) * $signed({{XLEN{in2[XLEN-1]}}, in2});
  assign umul = {{XLEN{1'b0}}, in1} * {{XLEN{1'b0}}, in2};

  // Signed divide runs on magnitudes; 0x80000000 is its own magnitude, so the
  // overflow case falls out as quotient 0x80000000, remainder 0.
  assign sdiv = (op == MD_DIV);
  assign mag1 = (sdiv && in1[XLEN-1]) ? -in1 : in1;
  assign mag2 = (sdiv && in2[XLEN-1]) ? -in2 : in2;
  // Substitute divisor keeps the divider X-free; the result is discarded anyway
  assign den  = (mag2 == '0) ? XLEN'(1) : mag2;
  assign uq   = mag1 / den;
  assign ur   = mag1 % den;

  // Result select
  always_comb begin
    res   = '0;
    valid = 1'b1;
    case (op)
      MD_MULT:  res = smul;
      MD_MULTU: res = umul;
      MD_DIV: begin
        res.lo = (in1[XLEN-1] ^ in2[XLEN-1]) ? -uq : uq;
        res.hi = in1[XLEN-1] ? -ur : ur;
        valid  = (in2 != '0);
      end
      MD_DIVU: begin
        res.lo = uq;
        res.hi = ur;
        valid  = (in2 != '0);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// Ports: clk, rst_n (async active-low), in1E/in2E (forwarded operands),
//        mdCtrE (op code), startE (valid MD instruction in E),
//        busyE (multi-cycle op in flight), mdOutE (MFHI/MFLO read, else 0).
module md_unit_e
  import md_unit_e_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] in1E,
  input  logic [XLEN-1:0] in2E,
  input  logic [3:0]      mdCtrE,
  input  logic            startE,
  output logic            busyE,
  output logic [XLEN-1:0] mdOutE
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XLEN-1:0] hi, hi_n, lo, lo_n;
  md_pair_t        shadow, shadow_n;
  logic            shadow_ok, shadow_ok_n;
  logic            busy_n;
  md_pair_t        arith_res;
  logic            arith_ok;

  md_arith u_arith (
    .op    (mdCtrE),
    .in1   (in1E),
    .in2   (in2E),
    .res   (arith_res),
    .valid (arith_ok)
  );

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      shadow    <= '0;
      shadow_ok <= 1'b0;
      busyE     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hi        <= hi_n;
      lo        <= lo_n;
      shadow    <= shadow_n;
      shadow_ok <= shadow_ok_n;
      busyE     <= busy_n;
    end
  end

  // Next-state: issue, countdown, commit; MTHI/MTLO only accepted while idle
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hi_n        = hi;
    lo_n        = lo;
    shadow_n    = shadow;
    shadow_ok_n = shadow_ok;
    busy_n      = busyE;
    case (state)
      ST_IDLE: begin
        if (startE) begin
          if (is_multi(mdCtrE)) begin
            shadow_n    = arith_res;
            shadow_ok_n = arith_ok;
            cnt_n       = is_mult(mdCtrE) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy_n      = 1'b1;
            state_n     = ST_BUSY;
          end else if (mdCtrE == MD_MTHI) begin
            hi_n = in1E;
          end else if (mdCtrE == MD_MTLO) begin
            lo_n = in1E;
          end
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (shadow_ok) begin
            hi_n = shadow.hi;
            lo_n = shadow.lo;
          end
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Combinational read port of the committed HI/LO
  always_comb begin
    mdOutE = '0;
    if (mdCtrE == MD_MFHI)      mdOutE = hi;
    else if (mdCtrE == MD_MFLO) mdOutE = lo;
  end

endmodule

// File: tb/tb_md_unit_e.sv
// Directed self-checking bench for md_unit_e.
module tb_md_unit_e;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1E;
  logic [31:0] in2E;
  logic [3:0]  mdCtrE;
  logic        startE;
  logic        busyE;
  logic [31:0] mdOutE;

  int checks = 0;
  int errors = 0;

  md_unit_e dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in1E   (in1E),
    .in2E   (in2E),
    .mdCtrE (mdCtrE),
    .startE (startE),
    .busyE  (busyE),
    .mdOutE (mdOutE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Present an op for one rising edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdCtrE = op;
    in1E   = a;
    in2E   = b;
    startE = 1'b1;
    @(posedge clk);
    #1;
    startE = 1'b0;
    mdCtrE = 4'd0;
  endtask

  // Count negedges with busyE high until it drops (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busyE) n++;
      else break;
    end
  endtask

  task automatic read_chk(input string tag, input logic [3:0] op, input logic [31:0] exp);
    @(negedge clk);
    mdCtrE = op;
    #1;
    check(tag, mdOutE, exp);
    mdCtrE = 4'd0;
  endtask

  int n;

  initial begin
    rst_n  = 1'b0;
    in1E   = '0;
    in2E   = '0;
    mdCtrE = 4'd0;
    startE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_busy", {31'b0, busyE}, 32'h0);
    read_chk("rst_hi", 4'd7, 32'h0);
    read_chk("rst_lo", 4'd8, 32'h0);

    // MULT -3 * 5
    issue(4'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy_at_issue", {31'b0, busyE}, 32'h1);
    wait_idle(n);
    check("mult_busy_cycles", 32'(n), 32'd5);
    read_chk("mult_hi", 4'd7, 32'hFFFF_FFFF);
    read_chk("mult_lo", 4'd8, 32'hFFFF_FFF1);

    // MULTU max * max
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_busy_cycles", 32'(n), 32'd5);
    read_chk("multu_hi", 4'd7, 32'hFFFF_FFFE);
    read_chk("multu_lo", 4'd8, 32'h0000_0001);

    // DIV -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", 32'(n), 32'd10);
    read_chk("div_lo", 4'd8, 32'hFFFF_FFFD);
    read_chk("div_hi", 4'd7, 32'hFFFF_FFFF);

    // DIV overflow
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divov_busy_cycles", 32'(n), 32'd10);
    read_chk("divov_lo", 4'd8, 32'h8000_0000);
    read_chk("divov_hi", 4'd7, 32'h0);

    // MTHI/MTLO preload, then DIVU by zero keeps them
    issue(4'd5, 32'h0000_1234, 32'h0);
    issue(4'd6, 32'h0000_5678, 32'h0);
    check("mt_no_busy", {31'b0, busyE}, 32'h0);
    read_chk("mthi", 4'd7, 32'h0000_1234);
    read_chk("mtlo", 4'd8, 32'h0000_5678);
    issue(4'd4, 32'd99, 32'd0);
    wait_idle(n);
    check("div0_busy_cycles", 32'(n), 32'd10);
    read_chk("div0_hi", 4'd7, 32'h0000_1234);
    read_chk("div0_lo", 4'd8, 32'h0000_5678);

    // DIVU 100/7 with an MTLO attempted while busy
    issue(4'd4, 32'd100, 32'd7);
    @(negedge clk);
    check("busy_before_mtlo", {31'b0, busyE}, 32'h1);
    mdCtrE = 4'd6;
    in1E   = 32'h0000_AAAA;
    startE = 1'b1;
    @(posedge clk);
    #1;
    startE = 1'b0;
    @(negedge clk);
    mdCtrE = 4'd8;
    #1;
    check("mf_while_busy_lo", mdOutE, 32'h0000_5678);
    check("busy_after_mtlo", {31'b0, busyE}, 32'h1);
    mdCtrE = 4'd0;
    wait_idle(n);
    check("divu_rest_cycles", 32'(n), 32'd8);
    read_chk("divu_lo", 4'd8, 32'd14);
    read_chk("divu_hi", 4'd7, 32'd2);

    // MULT 3*4, then a DIV issued while busy must not restart it
    issue(4'd1, 32'd3, 32'd4);
    issue(4'd3, 32'd100, 32'd3);
    wait_idle(n);
    check("norestart_cycles", 32'(n), 32'd4);
    read_chk("norestart_lo", 4'd8, 32'd12);
    read_chk("norestart_hi", 4'd7, 32'd0);

    // Reset abort mid-DIV
    issue(4'd5, 32'h0000_0077, 32'h0);
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    mdCtrE = 4'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busyE}, 32'h0);
    check("abort_hi", mdOutE, 32'h0);
    mdCtrE = 4'd8;
    #1;
    check("abort_lo", mdOutE, 32'h0);
    mdCtrE = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_busy", {31'b0, busyE}, 32'h0);
    read_chk("post_abort_hi", 4'd7, 32'h0);
    read_chk("post_abort_lo", 4'd8, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
